mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 63 ++++++
 rtl/mem_stage_load_ext.sv | 21 ++
 rtl/mem_stage.sv | 140 ++++++++++++++
 tb/tb_mem_stage.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared widths, instruction-type codes and FSM encodings for the MEM stage.
// Helper functions classify memory instruction types.
package mem_stage_pkg;

    localparam int unsigned RegBus      = 32;
    localparam int unsigned RegAddrBus  = 5;
    localparam int unsigned InstTypeBus = 5;

    localparam logic                  RstEnable    = 1'b1;
    localparam logic                  WriteEnable  = 1'b1;
    localparam logic                  WriteDisable = 1'b0;
    localparam logic [RegBus-1:0]     ZeroWord     = '0;
    localparam logic [RegAddrBus-1:0] NOPRegAdder  = '0;

    typedef enum logic [InstTypeBus-1:0] {
        INST_NOP = 5'd0,
        INST_ADD = 5'd1,
        INST_SUB = 5'd2,
        INST_AND = 5'd3,
        INST_OR  = 5'd4,
        INST_XOR = 5'd5,
        INST_SLL = 5'd6,
        INST_LUI = 5'd7,
        INST_LB  = 5'd16,
        INST_LH  = 5'd17,
        INST_LW  = 5'd18,
        INST_LBU = 5'd19,
        INST_LHU = 5'd20,
        INST_SB  = 5'd24,
        INST_SH  = 5'd25,
        INST_SW  = 5'd26
    } inst_type_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_e;

    function automatic logic is_load_type(input logic [InstTypeBus-1:0] t);
        case (t)
            INST_LB, INST_LH, INST_LW, INST_LBU, INST_LHU: return 1'b1;
            default:                                      return 1'b0;
        endcase
    endfunction

    function automatic logic is_store_type(input logic [InstTypeBus-1:0] t);
        case (t)
            INST_SB, INST_SH, INST_SW: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    // Index of the final byte of the access (byte count minus one).
    function automatic logic [1:0] last_byte_idx(input logic [InstTypeBus-1:0] t);
        case (t)
            INST_LH, INST_LHU, INST_SH: return 2'd1;
            INST_LW, INST_SW:           return 2'd3;
            default:                    return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_load_ext.sv
// Sign/zero extension of an assembled load word according to the load type.
module load_ext
    import mem_stage_pkg::*;
(
    input  logic [RegBus-1:0]      i_word,
    input  logic [InstTypeBus-1:0] i_inst_type,
    output logic [RegBus-1:0]      o_value
);

    always_comb begin
        o_value = i_word;
        case (i_inst_type)
            INST_LB:  o_value = {{24{i_word[7]}}, i_word[7:0]};
            INST_LBU: o_value = {24'h000000, i_word[7:0]};
            INST_LH:  o_value = {{16{i_word[15]}}, i_word[15:0]};
            INST_LHU: o_value = {16'h0000, i_word[15:0]};
            default:  o_value = i_word;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: passes ALU results through, and serialises loads/stores
// into byte accesses on a simple req/ack memory port while stalling the pipe.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic                   rd_mem_in,
    input  logic [RegBus-1:0]      rd_val_mem_in,
    input  logic [RegAddrBus-1:0]  rd_addr_mem_in,
    input  logic [InstTypeBus-1:0] inst_type_mem_in,
    input  logic [RegBus-1:0]      st_data_mem_in,
    output logic                   rd_wb_out,
    output logic [RegBus-1:0]      rd_val_wb_out,
    output logic [RegAddrBus-1:0]  rd_addr_wb_out,
    output logic                   stall_req_out,
    output logic                   mem_req_out,
    output logic                   mem_we_out,
    output logic [RegBus-1:0]      mem_addr_out,
    output logic [7:0]             mem_wdata_out,
    input  logic                   mem_ack_in,
    input  logic [7:0]             mem_rdata_in
);

    mem_state_e        r_state;
    mem_state_e        w_state_nxt;
    logic [1:0]        r_byte_idx;
    logic [1:0]        w_byte_idx_nxt;
    logic [RegBus-1:0] r_asm;
    logic [RegBus-1:0] w_asm_nxt;

    logic              w_is_load;
    logic              w_is_store;
    logic              w_is_mem;
    logic [1:0]        w_last;
    logic [RegBus-1:0] w_byte_addr;
    logic [7:0]        w_wdata_byte;
    logic [RegBus-1:0] w_ext;

    assign w_is_load    = is_load_type(inst_type_mem_in);
    assign w_is_store   = is_store_type(inst_type_mem_in);
    assign w_is_mem     = w_is_load | w_is_store;
    assign w_last       = last_byte_idx(inst_type_mem_in);
    assign w_byte_addr  = rd_val_mem_in + {30'b0, r_byte_idx};
    assign w_wdata_byte = st_data_mem_in[{r_byte_idx, 3'b000} +: 8];

    load_ext u_load_ext (
        .i_word      (r_asm),
        .i_inst_type (inst_type_mem_in),
        .o_value     (w_ext)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in == RstEnable) begin
            r_state    <= IDLE;
            r_byte_idx <= '0;
            r_asm      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_byte_idx <= w_byte_idx_nxt;
            r_asm      <= w_asm_nxt;
        end
    end

    // All state advances are gated by rdy_in; outputs follow the held state,
    // so stall_req_out naturally keeps its value while frozen.
    always_comb begin
        w_state_nxt    = r_state;
        w_byte_idx_nxt = r_byte_idx;
        w_asm_nxt      = r_asm;
        rd_wb_out      = rd_mem_in;
        rd_val_wb_out  = rd_val_mem_in;
        rd_addr_wb_out = rd_addr_mem_in;
        stall_req_out  = 1'b0;
        mem_req_out    = 1'b0;
        mem_we_out     = 1'b0;
        mem_addr_out   = '0;
        mem_wdata_out  = '0;

        case (r_state)
            IDLE: begin
                if (w_is_mem) begin
                    stall_req_out = 1'b1;
                    rd_wb_out     = WriteDisable;
                    rd_val_wb_out = ZeroWord;
                    if (rdy_in) begin
                        w_state_nxt    = ACCESS;
                        w_byte_idx_nxt = '0;
                        w_asm_nxt      = '0;
                    end
                end
            end
            ACCESS: begin
                stall_req_out = 1'b1;
                rd_wb_out     = WriteDisable;
                rd_val_wb_out = ZeroWord;
                mem_req_out   = rdy_in;
                mem_we_out    = w_is_store;
                mem_addr_out  = w_byte_addr;
                mem_wdata_out = w_wdata_byte;
                if (rdy_in && mem_ack_in) begin
                    if (w_is_load) begin
                        w_asm_nxt[{r_byte_idx, 3'b000} +: 8] = mem_rdata_in;
                    end
                    w_byte_idx_nxt = r_byte_idx + 2'd1;
                    if (r_byte_idx == w_last) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (w_is_load) begin
                    rd_val_wb_out = w_ext;
                end else begin
                    rd_wb_out     = WriteDisable;
                    rd_val_wb_out = ZeroWord;
                end
                if (rdy_in) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (rst_in == RstEnable) begin
            rd_wb_out      = WriteDisable;
            rd_val_wb_out  = ZeroWord;
            rd_addr_wb_out = NOPRegAdder;
            stall_req_out  = 1'b0;
            mem_req_out    = 1'b0;
            mem_we_out     = 1'b0;
            mem_addr_out   = '0;
            mem_wdata_out  = '0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected byte accesses and
// writebacks; a negedge monitor compares them; a responder models byte memory.
`timescale 1ns/1ps
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_in, rdy_in, rd_mem_in;
    logic [31:0] rd_val_mem_in, st_data_mem_in;
    logic [4:0]  rd_addr_mem_in;
    logic [4:0]  inst_type_mem_in;
    logic        rd_wb_out, stall_req_out, mem_req_out, mem_we_out;
    logic [31:0] rd_val_wb_out, mem_addr_out;
    logic [4:0]  rd_addr_wb_out;
    logic [7:0]  mem_wdata_out, mem_rdata_in;
    logic        mem_ack_in;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk_in           (clk),
        .rst_in           (rst_in),
        .rdy_in           (rdy_in),
        .rd_mem_in        (rd_mem_in),
        .rd_val_mem_in    (rd_val_mem_in),
        .rd_addr_mem_in   (rd_addr_mem_in),
        .inst_type_mem_in (inst_type_mem_in),
        .st_data_mem_in   (st_data_mem_in),
        .rd_wb_out        (rd_wb_out),
        .rd_val_wb_out    (rd_val_wb_out),
        .rd_addr_wb_out   (rd_addr_wb_out),
        .stall_req_out    (stall_req_out),
        .mem_req_out      (mem_req_out),
        .mem_we_out       (mem_we_out),
        .mem_addr_out     (mem_addr_out),
        .mem_wdata_out    (mem_wdata_out),
        .mem_ack_in       (mem_ack_in),
        .mem_rdata_in     (mem_rdata_in)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [7:0]  wdata;
    } acc_t;

    typedef struct packed {
        logic        wb;
        logic [31:0] val;
        logic [4:0]  addr;
        logic        chk_addr;
    } wb_t;

    acc_t exp_acc[$];
    wb_t  exp_wb[$];
    logic [7:0] model_mem [logic [31:0]];
    logic [7:0] dev_mem   [logic [31:0]];

    int checks = 0;
    int errors = 0;
    bit in_flight = 1'b0;
    int ack_delay = 0;
    bit spurious_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] seed_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A ^ {a[3:0], a[31:28]};
    endfunction

    function automatic logic [7:0] model_rd(input logic [31:0] a);
        if (model_mem.exists(a)) return model_mem[a];
        return seed_byte(a);
    endfunction

    function automatic logic [7:0] dev_rd(input logic [31:0] a);
        if (dev_mem.exists(a)) return dev_mem[a];
        return seed_byte(a);
    endfunction

    function automatic int tb_nbytes(input inst_type_e t);
        case (t)
            INST_LB, INST_LBU, INST_SB: return 1;
            INST_LH, INST_LHU, INST_SH: return 2;
            INST_LW, INST_SW:           return 4;
            default:                    return 0;
        endcase
    endfunction

    function automatic bit tb_is_store(input inst_type_e t);
        return (t == INST_SB) || (t == INST_SH) || (t == INST_SW);
    endfunction

    task automatic preset(input logic [31:0] a, input logic [7:0] b);
        model_mem[a] = b;
        dev_mem[a]   = b;
    endtask

    // Byte-memory responder: acks after a chosen delay, optionally emits stray acks.
    initial begin : responder
        int wait_cnt;
        wait_cnt     = -1;
        mem_ack_in   = 1'b0;
        mem_rdata_in = 8'h00;
        forever begin
            @(posedge clk);
            #2;
            if (rst_in) begin
                mem_ack_in = 1'b0;
                wait_cnt   = -1;
            end else if (mem_req_out) begin
                if (wait_cnt < 0)
                    wait_cnt = (ack_delay < 0) ? int'($urandom_range(0, 2)) : ack_delay;
                if (wait_cnt == 0) begin
                    mem_ack_in = 1'b1;
                    wait_cnt   = -1;
                    if (mem_we_out) dev_mem[mem_addr_out] = mem_wdata_out;
                    else            mem_rdata_in = dev_rd(mem_addr_out);
                end else begin
                    mem_ack_in   = 1'b0;
                    mem_rdata_in = 8'($urandom);
                    wait_cnt--;
                end
            end else begin
                mem_ack_in   = spurious_en && ($urandom_range(0, 7) == 0);
                mem_rdata_in = 8'($urandom);
            end
        end
    end

    always @(negedge clk) begin : monitor
        acc_t e;
        wb_t  w;
        if (rst_in) begin
            chk("rst_rd_wb", 32'(rd_wb_out), 32'(0));
            chk("rst_rd_val", rd_val_wb_out, 32'h0);
            chk("rst_rd_addr", 32'(rd_addr_wb_out), 32'(0));
            chk("rst_stall", 32'(stall_req_out), 32'(0));
            chk("rst_mem_req", 32'(mem_req_out), 32'(0));
            chk("rst_mem_we", 32'(mem_we_out), 32'(0));
            chk("rst_mem_addr", mem_addr_out, 32'h0);
            chk("rst_mem_wdata", 32'(mem_wdata_out), 32'(0));
        end else begin
            if (!rdy_in) chk("req_while_frozen", 32'(mem_req_out), 32'(0));
            if (stall_req_out) chk("no_early_wb", 32'(rd_wb_out), 32'(0));
            if (mem_req_out) begin
                if (exp_acc.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got request at 0x%08h expected no request", mem_addr_out);
                end else begin
                    e = exp_acc[0];
                    chk("acc_addr", mem_addr_out, e.addr);
                    chk("acc_we", 32'(mem_we_out), 32'(e.we));
                    if (e.we) chk("acc_wdata", 32'(mem_wdata_out), 32'(e.wdata));
                    if (mem_ack_in) void'(exp_acc.pop_front());
                end
            end
            if (in_flight && !stall_req_out && rdy_in) begin
                in_flight = 1'b0;
                chk("retire_no_req", 32'(mem_req_out), 32'(0));
                if (exp_wb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_retire: got retire with val 0x%08h expected none", rd_val_wb_out);
                end else begin
                    w = exp_wb.pop_front();
                    chk("wb_en", 32'(rd_wb_out), 32'(w.wb));
                    chk("wb_val", rd_val_wb_out, w.val);
                    if (w.chk_addr) chk("wb_addr", 32'(rd_addr_wb_out), 32'(w.addr));
                end
            end
        end
    end

    // Presents one instruction, pushes its expected behaviour, and holds it
    // until the stage releases the stall with rdy_in high.
    task automatic issue(input inst_type_e t, input logic [31:0] v, input logic [31:0] sd,
                         input logic rd, input logic [4:0] ra, input bit rnd_rdy,
                         input int freeze_after, output int cycles, output int stall_cycles);
        int          n;
        int          frz;
        bit          froze;
        logic [31:0] word;
        logic [31:0] a;
        logic [7:0]  b;
        wb_t         w;
        n = tb_nbytes(t);
        inst_type_mem_in = t;
        rd_val_mem_in    = v;
        st_data_mem_in   = sd;
        rd_mem_in        = rd;
        rd_addr_mem_in   = ra;
        word = 32'h0;
        for (int i = 0; i < n; i++) begin
            a = v + 32'(i);
            if (tb_is_store(t)) begin
                b = 8'(sd >> (8 * i));
                model_mem[a] = b;
                exp_acc.push_back('{addr: a, we: 1'b1, wdata: b});
            end else begin
                b = model_rd(a);
                word = word | (32'(b) << (8 * i));
                exp_acc.push_back('{addr: a, we: 1'b0, wdata: 8'h00});
            end
        end
        w.addr = ra;
        w.chk_addr = 1'b1;
        if (n == 0) begin
            w.wb  = rd;
            w.val = v;
        end else if (tb_is_store(t)) begin
            w.wb  = 1'b0;
            w.val = 32'h0;
            w.chk_addr = 1'b0;
        end else begin
            w.wb = rd;
            case (t)
                INST_LB: w.val = (word >= 32'd128)   ? word - 32'd256   : word;
                INST_LH: w.val = (word >= 32'd32768) ? word - 32'd65536 : word;
                default: w.val = word;
            endcase
        end
        exp_wb.push_back(w);
        in_flight    = 1'b1;
        cycles       = 0;
        stall_cycles = 0;
        froze        = 1'b0;
        frz          = 0;
        while (1) begin
            if (frz > 0) begin
                rdy_in = 1'b0;
                frz--;
            end else if (freeze_after >= 0 && !froze && (n - exp_acc.size()) == freeze_after) begin
                rdy_in = 1'b0;
                frz    = 2;
                froze  = 1'b1;
            end else begin
                rdy_in = rnd_rdy ? ($urandom_range(0, 5) != 0) : 1'b1;
            end
            @(negedge clk);
            cycles++;
            if (stall_req_out) stall_cycles++;
            if (!stall_req_out && rdy_in) begin
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
            if (cycles > 300) begin
                checks++;
                errors++;
                $display("FAIL issue_timeout: got %0d cycles without retire expected at most 300", cycles);
                in_flight = 1'b0;
                exp_acc.delete();
                exp_wb.delete();
                break;
            end
        end
    endtask

    initial begin : stimulus
        int cyc, stl;
        inst_type_e t;
        inst_type_e types[14];
        types = '{INST_NOP, INST_ADD, INST_SUB, INST_XOR, INST_LUI, INST_LB, INST_LH,
                  INST_LW, INST_LBU, INST_LHU, INST_SB, INST_SH, INST_SW, INST_LW};

        rst_in = 1'b1;
        rdy_in = 1'b0;
        rd_mem_in = 1'b0;
        rd_val_mem_in = 32'h0;
        rd_addr_mem_in = 5'd0;
        inst_type_mem_in = INST_LW;
        st_data_mem_in = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst_in = 1'b0;
        rdy_in = 1'b1;
        inst_type_mem_in = INST_NOP;

        issue(INST_ADD, 32'h12345678, 32'h0, 1'b1, 5'd5, 1'b0, -1, cyc, stl);
        chk("add_latency", 32'(cyc), 32'd1);
        chk("add_stall", 32'(stl), 32'd0);

        preset(32'h100, 8'h78); preset(32'h101, 8'h56);
        preset(32'h102, 8'h34); preset(32'h103, 8'h12);
        issue(INST_LW, 32'h100, 32'h0, 1'b1, 5'd7, 1'b0, -1, cyc, stl);
        chk("lw_latency", 32'(cyc), 32'd6);
        chk("lw_stall", 32'(stl), 32'd5);

        preset(32'h200, 8'h80);
        issue(INST_LB, 32'h200, 32'h0, 1'b1, 5'd8, 1'b0, -1, cyc, stl);
        chk("lb_latency", 32'(cyc), 32'd3);
        issue(INST_LBU, 32'h200, 32'h0, 1'b1, 5'd9, 1'b0, -1, cyc, stl);
        preset(32'h210, 8'h00); preset(32'h211, 8'h80);
        issue(INST_LH, 32'h210, 32'h0, 1'b1, 5'd10, 1'b0, -1, cyc, stl);
        chk("lh_latency", 32'(cyc), 32'd4);

        ack_delay = 2;
        issue(INST_SH, 32'h300, 32'hAABBCCDD, 1'b1, 5'd11, 1'b0, -1, cyc, stl);
        chk("sh_latency", 32'(cyc), 32'd8);
        chk("sh_byte0", 32'(dev_rd(32'h300)), 32'h0000_00DD);
        chk("sh_byte1", 32'(dev_rd(32'h301)), 32'h0000_00CC);
        chk("sh_byte2_untouched", 32'(dev_rd(32'h302)), 32'(seed_byte(32'h302)));

        ack_delay = 0;
        issue(INST_SW, 32'h310, 32'h11223344, 1'b0, 5'd12, 1'b0, 2, cyc, stl);
        chk("sw_freeze_latency", 32'(cyc), 32'd9);
        chk("sw_byte0", 32'(dev_rd(32'h310)), 32'h44);
        chk("sw_byte1", 32'(dev_rd(32'h311)), 32'h33);
        chk("sw_byte2", 32'(dev_rd(32'h312)), 32'h22);
        chk("sw_byte3", 32'(dev_rd(32'h313)), 32'h11);

        // LW aborted by reset after its second byte: only two accesses expected.
        inst_type_mem_in = INST_LW;
        rd_val_mem_in    = 32'h400;
        rd_mem_in        = 1'b1;
        rd_addr_mem_in   = 5'd13;
        rdy_in           = 1'b1;
        exp_acc.push_back('{addr: 32'h400, we: 1'b0, wdata: 8'h00});
        exp_acc.push_back('{addr: 32'h401, we: 1'b0, wdata: 8'h00});
        in_flight = 1'b1;
        for (int k = 0; k < 20 && exp_acc.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        chk("abort_acks_seen", 32'(exp_acc.size()), 32'd0);
        rst_in = 1'b1;
        in_flight = 1'b0;
        exp_acc.delete();
        @(posedge clk);
        #1;
        rst_in = 1'b0;
        issue(INST_ADD, 32'hCAFEF00D, 32'h0, 1'b1, 5'd14, 1'b0, -1, cyc, stl);
        chk("post_reset_latency", 32'(cyc), 32'd1);

        issue(INST_LH, 32'hFFFF_FFFE, 32'h0, 1'b1, 5'd15, 1'b0, -1, cyc, stl);
        chk("lh_wrap_latency", 32'(cyc), 32'd4);
        issue(INST_LW, 32'hFFFF_FFFE, 32'h0, 1'b1, 5'd16, 1'b0, -1, cyc, stl);
        chk("lw_wrap_latency", 32'(cyc), 32'd6);

        ack_delay   = -1;
        spurious_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [31:0] v;
            t = types[$urandom_range(0, 13)];
            if (tb_nbytes(t) == 0)              v = $urandom;
            else if ($urandom_range(0, 15) == 0) v = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            else                                 v = 32'h500 + 32'($urandom_range(0, 63));
            issue(t, v, $urandom, 1'($urandom), 5'($urandom), 1'b1, -1, cyc, stl);
        end

        spurious_en      = 1'b0;
        inst_type_mem_in = INST_NOP;
        rdy_in           = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("acc_queue_drained", 32'(exp_acc.size()), 32'd0);
        chk("wb_queue_drained", 32'(exp_wb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish before 2 ms");
        $fatal(1);
    end

endmodule
